// File: rtl/q_episode_ctrl.sv
// Multi-episode sequencer for the Q-learning datapath: issues one (state, action) step at a time,
// picks actions epsilon-greedily from a 16-bit LFSR and ends episodes on goal state or step limit.
module q_episode_ctrl #(
  parameter int          STATES_WIDTH  = 4,
  parameter int          ACTIONS_WIDTH = 2,
  parameter int          ACTIONS       = 4,
  parameter int          MAX_STEPS     = 64,
  parameter int          EP_WIDTH      = 10,
  parameter int          EPS_WIDTH     = 8,
  parameter int          GOAL_STATE    = 15,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_start,
  input  logic                           i_abort,
  input  logic [STATES_WIDTH-1:0]        i_first_st,
  input  logic [EP_WIDTH-1:0]            i_num_ep,
  input  logic [EPS_WIDTH-1:0]           i_epsilon,
  input  logic [ACTIONS_WIDTH-1:0]       i_greedy_at,
  input  logic                           i_greedy_vld,
  input  logic [STATES_WIDTH-1:0]        i_next_st,
  input  logic                           i_upd_vld,
  output logic [STATES_WIDTH-1:0]        o_st,
  output logic                           o_st_vld,
  output logic [ACTIONS_WIDTH-1:0]       o_at,
  output logic                           o_at_vld,
  output logic                           o_explore,
  output logic [$clog2(MAX_STEPS+1)-1:0] o_step,
  output logic [EP_WIDTH-1:0]            o_episode,
  output logic                           o_busy,
  output logic                           o_finish
);
  localparam int SW = $clog2(MAX_STEPS + 1);
  localparam logic [STATES_WIDTH-1:0] GOAL     = STATES_WIDTH'(GOAL_STATE);
  localparam logic [ACTIONS_WIDTH:0]  ACT_N    = (ACTIONS_WIDTH + 1)'(ACTIONS);
  localparam logic [SW:0]             STEP_LIM = (SW + 1)'(MAX_STEPS);

  typedef enum logic [2:0] {IDLE, REQ, WAIT_G, ISSUE, WAIT_U, EP_END, DONE} state_t;

  state_t                     state_reg, state_next;
  logic [15:0]                lfsr_reg;
  logic [STATES_WIDTH-1:0]    st_reg;
  logic [ACTIONS_WIDTH-1:0]   at_reg;
  logic                       explore_reg;
  logic [SW-1:0]              step_reg;
  logic [EP_WIDTH-1:0]        ep_reg;
  logic [EP_WIDTH-1:0]        num_ep_reg;

  logic [15:0]                lfsr_adv;
  logic [ACTIONS_WIDTH-1:0]   rand_at;
  logic                       explore;
  logic [SW:0]                step_inc;
  logic [EP_WIDTH:0]          ep_inc;
  logic                       ep_last_step;
  logic                       run_last_ep;

  // Decision uses the freshly advanced LFSR value (x^16+x^14+x^13+x^11+1, Fibonacci form).
  assign lfsr_adv     = {lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5], lfsr_reg[15:1]};
  assign rand_at      = lfsr_adv[15 -: ACTIONS_WIDTH];
  assign explore      = (lfsr_adv[EPS_WIDTH-1:0] < i_epsilon) && ({1'b0, rand_at} < ACT_N);
  assign step_inc     = {1'b0, step_reg} + 1'b1;
  assign ep_inc       = {1'b0, ep_reg} + 1'b1;
  assign ep_last_step = (i_next_st == GOAL) || (step_inc == STEP_LIM);
  assign run_last_ep  = (ep_inc == {1'b0, num_ep_reg});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (i_abort) begin
      state_next = IDLE;
    end else begin
      unique case (state_reg)
        IDLE:    if (i_start) state_next = REQ;
        REQ:     state_next = WAIT_G;
        WAIT_G:  if (i_greedy_vld) state_next = ISSUE;
        ISSUE:   state_next = WAIT_U;
        WAIT_U:  if (i_upd_vld) state_next = ep_last_step ? EP_END : REQ;
        EP_END:  state_next = run_last_ep ? DONE : REQ;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    o_st_vld  = (state_reg == REQ);
    o_at_vld  = (state_reg == ISSUE);
    o_explore = (state_reg == ISSUE) && explore_reg;
    o_busy    = (state_reg != IDLE);
    o_finish  = (state_reg == DONE);
  end

  // Datapath registers; an abort freezes everything so counters hold their values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_reg    <= LFSR_SEED;
      st_reg      <= '0;
      at_reg      <= '0;
      explore_reg <= 1'b0;
      step_reg    <= '0;
      ep_reg      <= '0;
      num_ep_reg  <= '0;
    end else if (!i_abort) begin
      case (state_reg)
        IDLE: if (i_start) begin
          num_ep_reg <= (i_num_ep == '0) ? EP_WIDTH'(1) : i_num_ep;
          st_reg     <= i_first_st;
          step_reg   <= '0;
          ep_reg     <= '0;
        end
        WAIT_G: if (i_greedy_vld) begin
          lfsr_reg    <= lfsr_adv;
          at_reg      <= explore ? rand_at : i_greedy_at;
          explore_reg <= explore;
        end
        WAIT_U: if (i_upd_vld) begin
          step_reg <= step_inc[SW-1:0];
          st_reg   <= i_next_st;
        end
        EP_END: begin
          if (ep_reg != '1) ep_reg <= ep_inc[EP_WIDTH-1:0];
          if (!run_last_ep) begin
            st_reg   <= i_first_st;
            step_reg <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_st      = st_reg;
  assign o_at      = at_reg;
  assign o_step    = step_reg;
  assign o_episode = ep_reg;
endmodule

// File: tb/tb_q_episode_ctrl.sv
// Directed bench for q_episode_ctrl: a default instance plus a MAX_STEPS=4 / ACTIONS=3 instance.
module tb_q_episode_ctrl;
  logic       clk = 1'b0;
  logic       rst_n, i_start_a, i_start_b, i_abort;
  logic [3:0] i_first_st, i_next_st;
  logic [9:0] i_num_ep;
  logic [7:0] i_epsilon;
  logic [1:0] i_greedy_at;
  logic       i_greedy_vld, i_upd_vld;

  logic [3:0] a_st, b_st;
  logic [1:0] a_at, b_at;
  logic [6:0] a_step;
  logic [2:0] b_step;
  logic [9:0] a_episode, b_episode;
  logic       a_st_vld, a_at_vld, a_explore, a_busy, a_finish;
  logic       b_st_vld, b_at_vld, b_explore, b_busy, b_finish;

  int vec_cnt = 0, err_cnt = 0;
  int fin_a = 0, fin_b = 0, atv_a = 0, atv_b = 0;
  logic sel = 1'b0;

  always #5 clk = ~clk;

  q_episode_ctrl dut_a (
    .clk(clk), .rst_n(rst_n), .i_start(i_start_a), .i_abort(i_abort),
    .i_first_st(i_first_st), .i_num_ep(i_num_ep), .i_epsilon(i_epsilon),
    .i_greedy_at(i_greedy_at), .i_greedy_vld(i_greedy_vld), .i_next_st(i_next_st),
    .i_upd_vld(i_upd_vld), .o_st(a_st), .o_st_vld(a_st_vld), .o_at(a_at),
    .o_at_vld(a_at_vld), .o_explore(a_explore), .o_step(a_step),
    .o_episode(a_episode), .o_busy(a_busy), .o_finish(a_finish)
  );

  q_episode_ctrl #(.MAX_STEPS(4), .ACTIONS(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_start(i_start_b), .i_abort(i_abort),
    .i_first_st(i_first_st), .i_num_ep(i_num_ep), .i_epsilon(i_epsilon),
    .i_greedy_at(i_greedy_at), .i_greedy_vld(i_greedy_vld), .i_next_st(i_next_st),
    .i_upd_vld(i_upd_vld), .o_st(b_st), .o_st_vld(b_st_vld), .o_at(b_at),
    .o_at_vld(b_at_vld), .o_explore(b_explore), .o_step(b_step),
    .o_episode(b_episode), .o_busy(b_busy), .o_finish(b_finish)
  );

  logic [3:0] m_st;
  logic [1:0] m_at;
  logic       m_st_vld, m_at_vld, m_explore, m_busy;
  assign m_st      = sel ? b_st      : a_st;
  assign m_at      = sel ? b_at      : a_at;
  assign m_st_vld  = sel ? b_st_vld  : a_st_vld;
  assign m_at_vld  = sel ? b_at_vld  : a_at_vld;
  assign m_explore = sel ? b_explore : a_explore;
  assign m_busy    = sel ? b_busy    : a_busy;

  always @(negedge clk) begin
    if (a_finish) fin_a++;
    if (b_finish) fin_b++;
    if (a_at_vld) atv_a++;
    if (b_at_vld) atv_b++;
  end

  function automatic logic [15:0] lnext(input logic [15:0] x);
    return {x[0] ^ x[2] ^ x[3] ^ x[5], x[15:1]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_run(input logic which);
    if (which) i_start_b = 1'b1; else i_start_a = 1'b1;
    @(negedge clk);
    i_start_a = 1'b0;
    i_start_b = 1'b0;
  endtask

  task automatic wait_req;
    int n = 0;
    while (!m_st_vld && n < 40) begin @(negedge clk); n++; end
    if (!m_st_vld) check("req_timeout", 32'(m_st_vld), 32'd1);
  endtask

  task automatic wait_idle;
    int n = 0;
    while (m_busy && n < 40) begin @(negedge clk); n++; end
    check("idle", 32'(m_busy), 32'd0);
  endtask

  task automatic pulse_greedy(input logic [1:0] g);
    i_greedy_at = g; i_greedy_vld = 1'b1;
    @(negedge clk);
    i_greedy_vld = 1'b0;
  endtask

  task automatic pulse_upd(input logic [3:0] n);
    i_next_st = n; i_upd_vld = 1'b1;
    @(negedge clk);
    i_upd_vld = 1'b0;
  endtask

  // One full step: REQ -> WAIT_G (greedy) -> ISSUE (capture action) -> WAIT_U (update).
  task automatic do_step(input logic [1:0] g, input logic [3:0] n,
                         output logic [1:0] at, output logic ex, output logic [3:0] st);
    wait_req;
    st = m_st;
    @(negedge clk);
    pulse_greedy(g);
    check("at_vld", 32'(m_at_vld), 32'd1);
    at = m_at;
    ex = m_explore;
    @(negedge clk);
    pulse_upd(n);
    $display("step dut=%0d st=%0d greedy=%0d at=%0d explore=%0d next=%0d", sel, st, g, at, ex, n);
  endtask

  logic [1:0]  at, g, rnd, at_e, trace_at[15];
  logic        ex, ex_e;
  logic [3:0]  st;
  logic [15:0] lfsr_a, lfsr_b;
  int          atv0, fallbacks = 0;

  initial begin
    rst_n = 1'b0; i_start_a = 1'b0; i_start_b = 1'b0; i_abort = 1'b0;
    i_first_st = '0; i_num_ep = '0; i_epsilon = '0; i_greedy_at = '0;
    i_greedy_vld = 1'b0; i_next_st = '0; i_upd_vld = 1'b0;
    lfsr_a = 16'hACE1; lfsr_b = 16'hACE1;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(a_busy), 0);
    check("rst_outs", {a_st, a_at, a_step, a_episode, a_st_vld, a_at_vld, a_explore, a_finish}, 0);
    check("rst_outs_b", {b_st, b_at, b_step, b_episode, b_busy, b_finish}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: greedy-only single episode, walks 0..15 and ends on the goal state
    sel = 1'b0; i_epsilon = 8'd0; i_first_st = 4'd0; i_num_ep = 10'd1;
    start_run(1'b0);
    for (int k = 0; k < 15; k++) begin
      do_step(2'(k % 4), 4'(k + 1), at, ex, st);
      trace_at[k] = at;
      check("t1_st", 32'(st), 32'(k));
      check("t1_at", 32'(at), 32'(k % 4));
      check("t1_explore", 32'(ex), 0);
    end
    wait_idle;
    check("t1_finish", 32'(fin_a), 1);
    check("t1_episode", 32'(a_episode), 1);
    check("t1_step", 32'(a_step), 15);
    check("t1_st_final", 32'(a_st), 15);

    // 2: step limit 4, three episodes, state reloads every episode
    sel = 1'b1; i_first_st = 4'd2; i_num_ep = 10'd3;
    start_run(1'b1);
    for (int k = 0; k < 12; k++) begin
      g = 2'(k % 3);
      lfsr_b = lnext(lfsr_b);
      do_step(g, 4'(2 + (k % 4) + 1), at, ex, st);
      check("t2_st", 32'(st), 32'(2 + (k % 4)));
      check("t2_at", 32'(at), 32'(g));
    end
    wait_idle;
    check("t2_finish", 32'(fin_b), 1);
    check("t2_at_vld_cnt", 32'(atv_b), 12);
    check("t2_episode", 32'(b_episode), 3);
    check("t2_step", 32'(b_step), 4);
    check("t2_st_final", 32'(b_st), 6);

    // 3: full exploration against an LFSR model; ACTIONS=3 so rand_at==3 must fall back
    i_epsilon = 8'hFF; i_first_st = 4'd0; i_num_ep = 10'd4;
    start_run(1'b1);
    for (int k = 0; k < 16; k++) begin
      g = 2'(k % 3);
      lfsr_b = lnext(lfsr_b);
      rnd  = lfsr_b[15:14];
      ex_e = (lfsr_b[7:0] < 8'hFF) && (rnd < 2'd3);
      at_e = ex_e ? rnd : g;
      if (lfsr_b[7:0] != 8'hFF && rnd == 2'd3) fallbacks++;
      do_step(g, 4'((k % 4) + 1), at, ex, st);
      check("t3_explore", 32'(ex), 32'(ex_e));
      check("t3_at", 32'(at), 32'(at_e));
    end
    wait_idle;
    check("t3_finish", 32'(fin_b), 2);
    $display("info: %0d greedy fallbacks from out-of-range random action", fallbacks);

    // 4: abort while waiting for the step-3 update, then a clean run with i_num_ep=0
    sel = 1'b0; i_epsilon = 8'd0; i_first_st = 4'd0; i_num_ep = 10'd2;
    start_run(1'b0);
    do_step(2'd0, 4'd1, at, ex, st);
    do_step(2'd1, 4'd2, at, ex, st);
    wait_req;
    @(negedge clk);
    pulse_greedy(2'd1);
    check("t4_at_vld", 32'(a_at_vld), 1);
    @(negedge clk);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    check("t4_abort_idle", 32'(a_busy), 0);
    pulse_upd(4'd9);
    check("t4_late_upd_busy", 32'(a_busy), 0);
    check("t4_hold_st", 32'(a_st), 2);
    check("t4_hold_step", 32'(a_step), 2);
    check("t4_no_finish", 32'(fin_a), 1);
    i_num_ep = 10'd0; i_first_st = 4'd13;
    start_run(1'b0);
    do_step(2'd0, 4'd14, at, ex, st);
    check("t4_restart_st", 32'(st), 13);
    do_step(2'd1, 4'd15, at, ex, st);
    wait_idle;
    check("t4_finish", 32'(fin_a), 2);
    check("t4_episode", 32'(a_episode), 1);
    check("t4_step", 32'(a_step), 2);

    // 5: stray pulses and a start while busy change nothing
    i_first_st = 4'd12; i_num_ep = 10'd1;
    atv0 = atv_a;
    start_run(1'b0);
    wait_req;
    @(negedge clk);
    pulse_upd(4'd15);
    check("t5_stray_upd_step", 32'(a_step), 0);
    check("t5_stray_upd_st", 32'(a_st), 12);
    check("t5_stray_upd_atv", 32'(a_at_vld), 0);
    i_first_st = 4'd3;
    start_run(1'b0);
    check("t5_busy_start_st", 32'(a_st), 12);
    check("t5_busy_start_stv", 32'(a_st_vld), 0);
    i_first_st = 4'd12;
    pulse_greedy(2'd2);
    check("t5_at_vld", 32'(a_at_vld), 1);
    check("t5_at", 32'(a_at), 2);
    @(negedge clk);
    pulse_greedy(2'd3);
    check("t5_stray_g_atv", 32'(a_at_vld), 0);
    check("t5_stray_g_stv", 32'(a_st_vld), 0);
    check("t5_stray_g_at", 32'(a_at), 2);
    pulse_upd(4'd13);
    do_step(2'd0, 4'd14, at, ex, st);
    do_step(2'd1, 4'd15, at, ex, st);
    wait_idle;
    check("t5_at_vld_cnt", 32'(atv_a - atv0), 3);
    check("t5_finish", 32'(fin_a), 3);
    check("t5_step", 32'(a_step), 3);

    // 6: async reset mid-episode, then the test-1 run and an LFSR run from the reseeded value
    i_first_st = 4'd0;
    start_run(1'b0);
    for (int k = 0; k < 5; k++) do_step(2'(k % 4), 4'(k + 1), at, ex, st);
    wait_req;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_busy", 32'(a_busy), 0);
    check("t6_async_outs", {a_st, a_at, a_step, a_episode, a_st_vld, a_at_vld, a_explore, a_finish}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    lfsr_a = 16'hACE1;
    @(negedge clk);
    start_run(1'b0);
    for (int k = 0; k < 15; k++) begin
      lfsr_a = lnext(lfsr_a);
      do_step(2'(k % 4), 4'(k + 1), at, ex, st);
      check("t6_trace_st", 32'(st), 32'(k));
      check("t6_trace_at", 32'(at), 32'(trace_at[k]));
    end
    wait_idle;
    check("t6_finish", 32'(fin_a), 4);
    i_epsilon = 8'hFF; i_first_st = 4'd12;
    start_run(1'b0);
    for (int k = 0; k < 3; k++) begin
      g = 2'(k + 1);
      lfsr_a = lnext(lfsr_a);
      ex_e = (lfsr_a[7:0] < 8'hFF);
      at_e = ex_e ? lfsr_a[15:14] : g;
      do_step(g, 4'(13 + k), at, ex, st);
      check("t6_lfsr_explore", 32'(ex), 32'(ex_e));
      check("t6_lfsr_at", 32'(at), 32'(at_e));
    end
    wait_idle;
    check("t6_lfsr_finish", 32'(fin_a), 5);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=completion");
    $fatal(1, "watchdog");
  end
endmodule
